hour_counter_bcd: RTL and testbench
===================================

Name: hour_counter_bcd

Overview:
- BCD hour counter. Direct upstream stage of the hours display controller: supplies its right-hour (4-bit BCD) and left-hour (2-bit) digit inputs.
- Advances once per minute-rollover tick from the minutes counter, wraps 23→00, and emits a day-carry pulse.
- Accepts a validated parallel load from the set/alarm path.
- Freezes counting while the user is in set mode.

Parameters:
- RESET_LH, 0, left-hour digit loaded on reset (0..2)
- RESET_RH, 0, right-hour digit loaded on reset (0..9; RESET_LH*10+RESET_RH ≤ 23)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- hr_tick  in  1  one-cycle pulse: minutes rolled 59→00
- set_mode  in  1  level; high = user setting time, counting frozen
- load_stb  in  1  one-cycle pulse: load set_lh/set_rh
- set_lh  in  2  left-hour digit to load
- set_rh  in  4  right-hour digit to load
- left_hr  out  2  current left-hour digit (0..2)
- right_hr  out  4  current right-hour digit (0..9)
- day_carry  out  1  one-cycle pulse on 23→00 wrap
- load_err  out  1  one-cycle pulse: load rejected as invalid
- frozen  out  1  high while in SET state

Behaviour:
- Reset (async, rst_n=0): left_hr=RESET_LH, right_hr=RESET_RH, day_carry=0, load_err=0, state=RUN, frozen=0. All outputs are registered.
- FSM states RUN, SET, COMMIT:
  - RUN: on hr_tick, increment; set_mode=1 → SET next cycle. A hr_tick in the same cycle as set_mode rising is still applied.
  - SET: hr_tick ignored and dropped, not queued; frozen=1. On load_stb → COMMIT. On set_mode=0 → RUN.
  - COMMIT (1 cycle): write the validated load, then → SET if set_mode=1, else RUN. frozen=1.
- Increment:
  - right_hr<9 and not 23 → right_hr+1.
  - right_hr==9 → right_hr=0, left_hr+1.
  - 23 → 00, day_carry=1 for exactly that cycle.
- Load validation, checked in the load_stb cycle and registered into COMMIT:
  - Valid iff set_rh≤9, set_lh≤2, and (set_lh<2 or set_rh≤3).
  - Invalid → digits unchanged; load_err=1 in the COMMIT cycle.
  - Valid loads never assert day_carry.
- load_stb in RUN is ignored; no load, no error.
- Latency: tick→new digits 1 cycle; load_stb→digits 2 cycles (SET→COMMIT→write visible).
- Digit outputs are never outside 00..23 after any sequence of inputs.
- Reset mid-COMMIT: pending load is discarded.

Optional Feature:
- Macro: HOUR_12H_EN.
- Defined:
  - Internal count stays 00..23; left_hr/right_hr present 12-hour form: 00→12, 13..23→01..11, 12→12.
  - Extra output pm (1 bit, registered) is high for internal 12..23.
  - Set inputs remain 24-hour.
  - day_carry is unchanged (internal 23→00).
- Undefined: no pm port; outputs are the 24-hour digits.

Decomposition:
- Package clock_pkg:
  - typedefs bcd_digit_t (4-bit) and lh_digit_t (2-bit)
  - constants MAX_LH=2, MAX_RH=9, MAX_RH_AT_LH2=3
  - state enum hr_state_e {RUN, SET, COMMIT}
- Natural sub-module: bcd_digit_counter, a single mod-N BCD digit with enable, synchronous load and carry-out. Two instances chained, with top-level 23→00 override.

Test Plan:
- Reset with RESET_LH=1, RESET_RH=2 → 12 immediately, asynchronously, without a clock edge; day_carry=0.
- From 08, pulse hr_tick twice → 09 then 10; each update one cycle after its tick.
- From 23, hr_tick → 00 with day_carry high exactly one cycle.
- set_mode=1, hr_tick pulses, load_stb with set_lh=1, set_rh=7 → tick dropped, frozen=1, digits become 17 two cycles after load_stb, load_err=0.
- In SET, load set_lh=2, set_rh=5 → digits unchanged, load_err pulses once. Repeat with set_rh=10 and set_lh=3 for the same response.
- With HOUR_12H_EN: internal 00 shows 12, pm=0; 13 shows 01, pm=1; 11→12 tick sets pm=1 and shows 12.

Source files
------------

// File: rtl/hour_counter_bcd_pkg.sv
// Shared types, digit limits, FSM states and the 12-hour display mapping for the hour counter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Optional feature macro: HOUR_12H_EN (adds disp_t and to12h).
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [1:0] lh_digit_t;

    localparam lh_digit_t  MAX_LH        = 2'd2;
    localparam bcd_digit_t MAX_RH        = 4'd9;
    localparam bcd_digit_t MAX_RH_AT_LH2 = 4'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET    = 2'd1,
        COMMIT = 2'd2
    } hr_state_e;

    // A load is accepted only if it names a real hour 00..23.
    function automatic logic loadIsValid(lh_digit_t lh, bcd_digit_t rh);
        return (rh <= MAX_RH) && (lh <= MAX_LH) && ((lh < MAX_LH) || (rh <= MAX_RH_AT_LH2));
    endfunction

`ifdef HOUR_12H_EN
    typedef struct packed {
        logic       pm;
        lh_digit_t  lh;
        bcd_digit_t rh;
    } disp_t;

    // 24-hour digits -> 12-hour digits: 00 -> 12, 13..23 -> 01..11, pm for 12..23.
    function automatic disp_t to12h(lh_digit_t lh, bcd_digit_t rh);
        logic [4:0] h;
        logic [4:0] h12;
        disp_t      d;
        h = 5'(lh) * 5'd10 + 5'(rh);
        if (h == 5'd0)       h12 = 5'd12;
        else if (h > 5'd12)  h12 = h - 5'd12;
        else                 h12 = h;
        d.pm = (h >= 5'd12);
        if (h12 >= 5'd10) begin
            d.lh = 2'd1;
            d.rh = 4'(h12 - 5'd10);
        end else begin
            d.lh = 2'd0;
            d.rh = h12[3:0];
        end
        return d;
    endfunction
`endif

endpackage

// File: rtl/hour_counter_bcd_if.sv
// Bundles the hour counter's control inputs and digit/status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; ticks and load strobes are single-cycle pulses that are never stalled.
// Optional feature macro: HOUR_12H_EN (adds pm).
interface hour_counter_bcd_if;
    import clock_pkg::*;

    logic       hr_tick;
    logic       set_mode;
    logic       load_stb;
    lh_digit_t  set_lh;
    bcd_digit_t set_rh;
    lh_digit_t  left_hr;
    bcd_digit_t right_hr;
    logic       day_carry;
    logic       load_err;
    logic       frozen;
`ifdef HOUR_12H_EN
    logic       pm;
`endif

    // master: minutes counter / set path side; slave: the hour counter.
    modport master (
        output hr_tick, set_mode, load_stb, set_lh, set_rh,
        input  left_hr, right_hr, day_carry, load_err, frozen
`ifdef HOUR_12H_EN
        , input pm
`endif
    );

    modport slave (
        input  hr_tick, set_mode, load_stb, set_lh, set_rh,
        output left_hr, right_hr, day_carry, load_err, frozen
`ifdef HOUR_12H_EN
        , output pm
`endif
    );
endinterface

// File: rtl/hour_counter_bcd_digit_counter.sv
// Single mod-(MAX+1) digit counter with enable, synchronous load and terminal-count flag.
// Latency: 1 cycle from en/ld to q; qNext exposes the value q takes on the next edge.
// Backpressure: none; ld has priority over en.
// Ports: clk, rst_n, en, ld, ldVal in; q (registered), qNext, carry (q at MAX) out.
module bcd_digit_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX       = WIDTH'(9),
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ldVal,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qNext,
    output logic             carry
);
    // carry marks the terminal value; the next digit advances when this one is enabled at carry.
    assign carry = (q == MAX);

    always_comb begin
        qNext = q;
        if (ld) begin
            qNext = ldVal;
        end else if (en) begin
            qNext = carry ? '0 : q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else begin
            q <= qNext;
        end
    end
endmodule

// File: rtl/hour_counter_bcd.sv
// BCD hour counter 00..23: advances on hr_tick, wraps 23->00 with day_carry, accepts validated loads in set mode.
// Latency: hr_tick -> digits 1 cycle; load_stb -> digits 2 cycles (SET -> COMMIT -> written).
// Backpressure: none; ticks in SET/COMMIT are dropped, load_stb outside SET is ignored.
// Ports: clk, rst_n (async active-low); bus (slave): hr_tick, set_mode, load_stb, set_lh, set_rh in;
//        left_hr, right_hr, day_carry, load_err, frozen (all registered) out.
// Optional feature macro: HOUR_12H_EN adds registered pm and presents 12-hour digits.
module hour_counter_bcd
    import clock_pkg::*;
#(
    parameter int RESET_LH = 0,
    parameter int RESET_RH = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hour_counter_bcd_if.slave        bus
);
    hr_state_e  state, stateNext;
    lh_digit_t  pendLh;
    bcd_digit_t pendRh;
    logic       pendOk;
    lh_digit_t  lhQ, lhNext;
    bcd_digit_t rhQ, rhNext;
    logic       rhCarry, lhCarry;
    logic       dayCarry, loadErr, frozenQ;

    logic inc, atMax, wrap, commitWr, loadCapture, loadOk;

    assign inc         = (state == RUN) && bus.hr_tick;
    assign atMax       = lhCarry && (rhQ == MAX_RH_AT_LH2);
    assign wrap        = inc && atMax;
    assign commitWr    = (state == COMMIT) && pendOk;
    assign loadCapture = (state == SET) && bus.load_stb;
    assign loadOk      = loadIsValid(bus.set_lh, bus.set_rh);

    // 23 -> 00 is forced through the load path; commit and wrap are mutually exclusive by state.
    bcd_digit_counter #(
        .WIDTH(4), .MAX(MAX_RH), .RESET_VAL(bcd_digit_t'(RESET_RH))
    ) u_rh (
        .clk(clk), .rst_n(rst_n),
        .en(inc), .ld(wrap || commitWr), .ldVal(commitWr ? pendRh : 4'd0),
        .q(rhQ), .qNext(rhNext), .carry(rhCarry)
    );

    bcd_digit_counter #(
        .WIDTH(2), .MAX(MAX_LH), .RESET_VAL(lh_digit_t'(RESET_LH))
    ) u_lh (
        .clk(clk), .rst_n(rst_n),
        .en(inc && rhCarry), .ld(wrap || commitWr), .ldVal(commitWr ? pendLh : 2'd0),
        .q(lhQ), .qNext(lhNext), .carry(lhCarry)
    );

    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (bus.set_mode) stateNext = SET;
            SET: begin
                if (bus.load_stb)      stateNext = COMMIT;
                else if (!bus.set_mode) stateNext = RUN;
            end
            COMMIT:  stateNext = bus.set_mode ? SET : RUN;
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pendLh   <= '0;
            pendRh   <= '0;
            pendOk   <= 1'b0;
            dayCarry <= 1'b0;
            loadErr  <= 1'b0;
            frozenQ  <= 1'b0;
        end else begin
            state    <= stateNext;
            dayCarry <= wrap;
            loadErr  <= loadCapture && !loadOk;
            frozenQ  <= (stateNext != RUN);
            if (loadCapture) begin
                pendLh <= bus.set_lh;
                pendRh <= bus.set_rh;
                pendOk <= loadOk;
            end
        end
    end

    assign bus.day_carry = dayCarry;
    assign bus.load_err  = loadErr;
    assign bus.frozen    = frozenQ;

`ifdef HOUR_12H_EN
    // Display is registered from the next internal count so it changes on the same edge.
    disp_t dispQ;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dispQ <= to12h(lh_digit_t'(RESET_LH), bcd_digit_t'(RESET_RH));
        end else begin
            dispQ <= to12h(lhNext, rhNext);
        end
    end
    assign bus.left_hr  = dispQ.lh;
    assign bus.right_hr = dispQ.rh;
    assign bus.pm       = dispQ.pm;
`else
    logic unusedNext;
    assign unusedNext   = ^{lhNext, rhNext};
    assign bus.left_hr  = lhQ;
    assign bus.right_hr = rhQ;
`endif
endmodule

// File: tb/tb_hour_counter_bcd.sv
// Bench for hour_counter_bcd: randomized and directed stimulus against an hour-number reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_hour_counter_bcd;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hour_counter_bcd_if bus();

    hour_counter_bcd #(.RESET_LH(1), .RESET_RH(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the hour as a plain number plus the mode the user is in.
    int hour;
    int mode;        // 0 counting, 1 setting, 2 committing a load
    int pendHour;
    bit pendOk;
    int expLh, expRh;
    bit expPm, expCarry, expErr, expFrozen;

    function automatic void refresh();
        int h12;
`ifdef HOUR_12H_EN
        h12 = hour % 12;
        if (h12 == 0) h12 = 12;
`else
        h12 = hour;
`endif
        expPm = (hour >= 12);
        expLh = h12 / 10;
        expRh = h12 % 10;
    endfunction

    function automatic void modelReset();
        hour = 12;
        mode = 0;
        pendOk = 1'b0;
        expCarry = 1'b0;
        expErr = 1'b0;
        expFrozen = 1'b0;
        refresh();
    endfunction

    task automatic cycle(input bit tick, input bit setm, input bit ld, input int lh, input int rh);
        @(negedge clk);
        bus.hr_tick  = tick;
        bus.set_mode = setm;
        bus.load_stb = ld;
        bus.set_lh   = lh[1:0];
        bus.set_rh   = rh[3:0];
        @(posedge clk);
        expCarry = 1'b0;
        expErr = 1'b0;
        case (mode)
            0: begin
                if (tick) begin
                    if (hour == 23) begin
                        hour = 0;
                        expCarry = 1'b1;
                    end else begin
                        hour = hour + 1;
                    end
                end
                if (setm) mode = 1;
            end
            1: begin
                if (ld) begin
                    pendHour = lh * 10 + rh;
                    pendOk = (rh <= 9) && (pendHour <= 23);
                    expErr = !pendOk;
                    mode = 2;
                end else if (!setm) begin
                    mode = 0;
                end
            end
            default: begin
                if (pendOk) hour = pendHour;
                mode = setm ? 1 : 0;
            end
        endcase
        expFrozen = (mode != 0);
        refresh();
        #1;
    endtask

    task automatic setHour(input int h);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, h / 10, h % 10);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        bus.hr_tick = 0; bus.set_mode = 0; bus.load_stb = 0; bus.set_lh = 0; bus.set_rh = 0;
        #2 rst_n = 1'b0;
        #1 modelReset();
        vectors++; if (bus.left_hr !== expLh[1:0]) begin miscompares++; $display("FAIL reset left_hr got %0d exp %0d", bus.left_hr, expLh); end
        vectors++; if (bus.right_hr !== expRh[3:0]) begin miscompares++; $display("FAIL reset right_hr got %0d exp %0d", bus.right_hr, expRh); end
        vectors++; if (bus.day_carry !== 1'b0) begin miscompares++; $display("FAIL reset day_carry got %b exp 0", bus.day_carry); end
        vectors++; if (bus.load_err !== 1'b0) begin miscompares++; $display("FAIL reset load_err got %b exp 0", bus.load_err); end
        vectors++; if (bus.frozen !== 1'b0) begin miscompares++; $display("FAIL reset frozen got %b exp 0", bus.frozen); end
`ifdef HOUR_12H_EN
        vectors++; if (bus.pm !== expPm) begin miscompares++; $display("FAIL reset pm got %b exp %b", bus.pm, expPm); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_increment();
        setHour(8);
        for (int i = 0; i < 3; i++) begin
            cycle(i < 2, 0, 0, 0, 0);
            vectors++; if (bus.left_hr !== expLh[1:0]) begin miscompares++; $display("FAIL inc left_hr step %0d got %0d exp %0d", i, bus.left_hr, expLh); end
            vectors++; if (bus.right_hr !== expRh[3:0]) begin miscompares++; $display("FAIL inc right_hr step %0d got %0d exp %0d", i, bus.right_hr, expRh); end
            vectors++; if (bus.day_carry !== 1'b0) begin miscompares++; $display("FAIL inc day_carry step %0d got %b exp 0", i, bus.day_carry); end
        end
    endtask

    task automatic test_wrap();
        setHour(23);
        for (int i = 0; i < 2; i++) begin
            cycle(i == 0, 0, 0, 0, 0);
            vectors++; if (bus.left_hr !== expLh[1:0]) begin miscompares++; $display("FAIL wrap left_hr got %0d exp %0d", bus.left_hr, expLh); end
            vectors++; if (bus.right_hr !== expRh[3:0]) begin miscompares++; $display("FAIL wrap right_hr got %0d exp %0d", bus.right_hr, expRh); end
            vectors++; if (bus.day_carry !== expCarry) begin miscompares++; $display("FAIL wrap day_carry cycle %0d got %b exp %b", i, bus.day_carry, expCarry); end
        end
    endtask

    task automatic test_set_load();
        setHour(5);
        // tick together with set_mode rising still counts; the next tick is dropped
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 1, 1, 7);
        cycle(0, 1, 0, 0, 0);
        vectors++; if (bus.left_hr !== expLh[1:0] || bus.right_hr !== expRh[3:0]) begin miscompares++; $display("FAIL set_load digits got %0d%0d exp %0d%0d", bus.left_hr, bus.right_hr, expLh, expRh); end
        vectors++; if (bus.frozen !== 1'b1) begin miscompares++; $display("FAIL set_load frozen got %b exp 1", bus.frozen); end
        vectors++; if (bus.load_err !== 1'b0) begin miscompares++; $display("FAIL set_load load_err got %b exp 0", bus.load_err); end
`ifndef HOUR_12H_EN
        vectors++; if (bus.left_hr !== 2'd1 || bus.right_hr !== 4'd7) begin miscompares++; $display("FAIL set_load value got %0d%0d exp 17", bus.left_hr, bus.right_hr); end
`endif
        cycle(0, 0, 0, 0, 0);
        vectors++; if (bus.frozen !== 1'b0) begin miscompares++; $display("FAIL set_load exit frozen got %b exp 0", bus.frozen); end
    endtask

    task automatic test_invalid();
        int badLh[3] = '{2, 1, 3};
        int badRh[3] = '{5, 10, 0};
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, badLh[i], badRh[i]);
            vectors++; if (bus.load_err !== 1'b1) begin miscompares++; $display("FAIL invalid%0d load_err got %b exp 1", i, bus.load_err); end
            cycle(0, 1, 0, 0, 0);
            vectors++; if (bus.load_err !== 1'b0) begin miscompares++; $display("FAIL invalid%0d err_pulse got %b exp 0", i, bus.load_err); end
            vectors++; if (bus.left_hr !== expLh[1:0] || bus.right_hr !== expRh[3:0]) begin miscompares++; $display("FAIL invalid%0d digits got %0d%0d exp %0d%0d", i, bus.left_hr, bus.right_hr, expLh, expRh); end
        end
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_commit();
        setHour(3);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 5);
        #2 rst_n = 1'b0;
        #1 modelReset();
        vectors++; if (bus.left_hr !== expLh[1:0] || bus.right_hr !== expRh[3:0]) begin miscompares++; $display("FAIL rst_commit digits got %0d%0d exp %0d%0d", bus.left_hr, bus.right_hr, expLh, expRh); end
        vectors++; if (bus.frozen !== 1'b0) begin miscompares++; $display("FAIL rst_commit frozen got %b exp 0", bus.frozen); end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        vectors++; if (bus.left_hr !== expLh[1:0] || bus.right_hr !== expRh[3:0]) begin miscompares++; $display("FAIL rst_commit discard got %0d%0d exp %0d%0d", bus.left_hr, bus.right_hr, expLh, expRh); end
    endtask

    task automatic test_random();
        bit setm = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) setm = !setm;
            cycle($urandom_range(0, 2) != 0, setm, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 15));
            vectors++; if (bus.left_hr !== expLh[1:0]) begin miscompares++; $display("FAIL rand%0d left_hr got %0d exp %0d", i, bus.left_hr, expLh); end
            vectors++; if (bus.right_hr !== expRh[3:0]) begin miscompares++; $display("FAIL rand%0d right_hr got %0d exp %0d", i, bus.right_hr, expRh); end
            vectors++; if (bus.day_carry !== expCarry) begin miscompares++; $display("FAIL rand%0d day_carry got %b exp %b", i, bus.day_carry, expCarry); end
            vectors++; if (bus.load_err !== expErr) begin miscompares++; $display("FAIL rand%0d load_err got %b exp %b", i, bus.load_err, expErr); end
            vectors++; if (bus.frozen !== expFrozen) begin miscompares++; $display("FAIL rand%0d frozen got %b exp %b", i, bus.frozen, expFrozen); end
`ifdef HOUR_12H_EN
            vectors++; if (bus.pm !== expPm) begin miscompares++; $display("FAIL rand%0d pm got %b exp %b", i, bus.pm, expPm); end
`endif
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
    endtask

`ifdef HOUR_12H_EN
    task automatic test_12h();
        setHour(0);
        vectors++; if (bus.left_hr !== 2'd1 || bus.right_hr !== 4'd2 || bus.pm !== 1'b0) begin miscompares++; $display("FAIL h12_00 got %0d%0d pm %b exp 12 pm 0", bus.left_hr, bus.right_hr, bus.pm); end
        setHour(13);
        vectors++; if (bus.left_hr !== 2'd0 || bus.right_hr !== 4'd1 || bus.pm !== 1'b1) begin miscompares++; $display("FAIL h12_13 got %0d%0d pm %b exp 01 pm 1", bus.left_hr, bus.right_hr, bus.pm); end
        setHour(11);
        cycle(1, 0, 0, 0, 0);
        vectors++; if (bus.left_hr !== 2'd1 || bus.right_hr !== 4'd2 || bus.pm !== 1'b1) begin miscompares++; $display("FAIL h12_11to12 got %0d%0d pm %b exp 12 pm 1", bus.left_hr, bus.right_hr, bus.pm); end
    endtask
`endif

    initial begin
        test_reset();
        test_increment();
        test_wrap();
        test_set_load();
        test_invalid();
        test_reset_commit();
`ifdef HOUR_12H_EN
        test_12h();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
